// File: rtl/mor1kx_rf_access_ctrl_if.sv
// mor1kx_rf_access_ctrl_if: pipeline, debug-unit and GPR RAM port bundle for the RF access controller
//   slave  : controller side (takes pipeline/debug requests and RAM read data; drives acks and RAM ports)
//   master : environment side (pipeline, debug unit and RAM model)
interface mor1kx_rf_access_ctrl_if #(
  parameter int ADDR_WIDTH    = 5,
  parameter int OPERAND_WIDTH = 32
);
  logic                     wb_rf_wb_i;
  logic [ADDR_WIDTH-1:0]    wb_rfd_adr_i;
  logic [OPERAND_WIDTH-1:0] result_i;
  logic                     fetch_rf_adr_valid_i;
  logic [ADDR_WIDTH-1:0]    fetch_rfb_adr_i;
  logic                     cpu_stall_i;
  logic                     du_req_i;
  logic                     du_we_i;
  logic [ADDR_WIDTH-1:0]    du_adr_i;
  logic [OPERAND_WIDTH-1:0] du_dat_i;
  logic                     du_ack_o;
  logic [OPERAND_WIDTH-1:0] du_dat_o;
  logic                     rf_init_busy_o;
  logic                     rf_wren_o;
  logic [ADDR_WIDTH-1:0]    rf_wrad_o;
  logic [OPERAND_WIDTH-1:0] rf_wrda_o;
  logic                     rf_rden_b_o;
  logic [ADDR_WIDTH-1:0]    rf_rdad_b_o;
  logic [OPERAND_WIDTH-1:0] rf_rdda_b_i;
  modport slave (
    input  wb_rf_wb_i, wb_rfd_adr_i, result_i, fetch_rf_adr_valid_i, fetch_rfb_adr_i,
           cpu_stall_i, du_req_i, du_we_i, du_adr_i, du_dat_i, rf_rdda_b_i,
    output du_ack_o, du_dat_o, rf_init_busy_o, rf_wren_o, rf_wrad_o, rf_wrda_o,
           rf_rden_b_o, rf_rdad_b_o
  );
  modport master (
    output wb_rf_wb_i, wb_rfd_adr_i, result_i, fetch_rf_adr_valid_i, fetch_rfb_adr_i,
           cpu_stall_i, du_req_i, du_we_i, du_adr_i, du_dat_i, rf_rdda_b_i,
    input  du_ack_o, du_dat_o, rf_init_busy_o, rf_wren_o, rf_wrad_o, rf_wrda_o,
           rf_rden_b_o, rf_rdad_b_o
  );
endinterface

// File: rtl/mor1kx_rf_access_ctrl.sv
// mor1kx_rf_access_ctrl: GPR RAM port arbiter with post-reset clear, debug access and port-B restore
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of mor1kx_rf_access_ctrl_if (pipeline wb/fetch, debug req/ack, RAM ports)
module mor1kx_rf_access_ctrl #(
  parameter int OPTION_RF_ADDR_WIDTH    = 5,
  parameter int OPTION_RF_WORDS         = 32,
  parameter int OPTION_OPERAND_WIDTH    = 32,
  parameter int OPTION_RF_CLEAR_ON_INIT = 1
) (
  input logic                     clk,
  input logic                     rst_n,
  mor1kx_rf_access_ctrl_if.slave  bus
);
  localparam int AW = OPTION_RF_ADDR_WIDTH;
  localparam int DW = OPTION_OPERAND_WIDTH;
  typedef enum logic [2:0] {CLEAR, IDLE, DU_RD, RESTORE, DONE} state_t;
  localparam state_t RST_STATE = (OPTION_RF_CLEAR_ON_INIT != 0) ? CLEAR : IDLE;
  state_t        state;
  logic [AW-1:0] clr_adr;
  logic [AW-1:0] last_fetch_adr;
  logic          byp;
  logic [DW-1:0] byp_dat;
  logic          clr_wr;
  logic          du_go;
  logic          du_wr;
  logic          du_rd;
  logic          last_clr;
  // A wb write steals the write port from the clear, which then holds its address.
  assign clr_wr   = state == CLEAR && !bus.wb_rf_wb_i;
  assign du_go    = state == IDLE && bus.du_req_i && bus.cpu_stall_i;
  assign du_wr    = du_go && bus.du_we_i && !bus.wb_rf_wb_i;
  assign du_rd    = du_go && !bus.du_we_i && !bus.fetch_rf_adr_valid_i;
  assign last_clr = clr_adr == AW'(OPTION_RF_WORDS - 1);
  assign bus.rf_init_busy_o = state == CLEAR;
  // Enables are qualified by rst_n so nothing reaches the RAMs while reset is held.
  always_comb begin
    bus.rf_wren_o   = rst_n && (bus.wb_rf_wb_i || clr_wr || du_wr);
    bus.rf_wrad_o   = bus.wb_rf_wb_i ? bus.wb_rfd_adr_i : clr_wr ? clr_adr : bus.du_adr_i;
    bus.rf_wrda_o   = bus.wb_rf_wb_i ? bus.result_i : clr_wr ? '0 : bus.du_dat_i;
    bus.rf_rden_b_o = rst_n && (bus.fetch_rf_adr_valid_i || du_rd || state == DU_RD);
    bus.rf_rdad_b_o = bus.fetch_rf_adr_valid_i ? bus.fetch_rfb_adr_i :
                      du_rd ? bus.du_adr_i : last_fetch_adr;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state          <= RST_STATE;
      clr_adr        <= '0;
      last_fetch_adr <= '0;
      byp            <= 1'b0;
      byp_dat        <= '0;
      bus.du_ack_o   <= 1'b0;
      bus.du_dat_o   <= '0;
    end else begin
      bus.du_ack_o <= 1'b0;
      if (bus.fetch_rf_adr_valid_i) last_fetch_adr <= bus.fetch_rfb_adr_i;
      case (state)
        CLEAR:
          if (clr_wr) begin
            clr_adr <= clr_adr + 1'b1;
            if (last_clr) state <= IDLE;
          end
        IDLE:
          if (du_wr) begin
            state        <= DONE;
            bus.du_ack_o <= 1'b1;
          end else if (du_rd) begin
            // The RAM returns pre-write data for a same-cycle wb write, so forward it.
            state   <= DU_RD;
            byp     <= bus.wb_rf_wb_i && bus.wb_rfd_adr_i == bus.du_adr_i;
            byp_dat <= bus.result_i;
          end
        DU_RD: begin
          bus.du_dat_o <= byp ? byp_dat : bus.rf_rdda_b_i;
          state        <= RESTORE;
        end
        RESTORE: begin
          state        <= DONE;
          bus.du_ack_o <= 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= RST_STATE;
      endcase
    end
endmodule

// File: tb/tb_mor1kx_rf_access_ctrl.sv
// tb_mor1kx_rf_access_ctrl: directed vector table plus multi-cycle sequences for the RF access controller
module tb_mor1kx_rf_access_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic prefill = 1'b1;
  int errors = 0;
  int checks = 0;
  logic [31:0] mem [32];
  mor1kx_rf_access_ctrl_if #(.ADDR_WIDTH(5), .OPERAND_WIDTH(32)) bus ();
  mor1kx_rf_access_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk)
    if (prefill) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'hBAD0_0000 | i;
      bus.rf_rdda_b_i <= 32'h0;
    end else begin
      if (bus.rf_wren_o) mem[bus.rf_wrad_o] <= bus.rf_wrda_o;
      if (bus.rf_rden_b_o) bus.rf_rdda_b_i <= mem[bus.rf_rdad_b_o];
    end
  typedef struct packed {
    logic stall; logic req; logic we; logic [4:0] dadr; logic [31:0] ddat;
    logic wb; logic [4:0] wadr; logic [31:0] res; logic fv; logic [4:0] fadr;
    logic e_wren; logic [4:0] e_wrad; logic [31:0] e_wrda; logic e_rden; logic [4:0] e_rdad;
  } vec_t;
  vec_t tv [8];
  logic tr_wren [16];
  logic tr_rden [16];
  logic [4:0] tr_wrad [16];
  logic [4:0] tr_rdad [16];
  int wb_hold = 0;
  int stall_drop = -1;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic idle_inputs();
    bus.wb_rf_wb_i = 0; bus.wb_rfd_adr_i = 0; bus.result_i = 0;
    bus.fetch_rf_adr_valid_i = 0; bus.fetch_rfb_adr_i = 0;
    bus.cpu_stall_i = 1; bus.du_req_i = 0; bus.du_we_i = 0; bus.du_adr_i = 0; bus.du_dat_i = 0;
  endtask
  task automatic do_clear(input int collide, output int busy_n);
    int bad;
    int ea;
    rst_n = 0;
    idle_inputs();
    bus.wb_rf_wb_i = 1; bus.wb_rfd_adr_i = 1; bus.result_i = 32'h99;
    bus.fetch_rf_adr_valid_i = 1; bus.fetch_rfb_adr_i = 1;
    @(negedge clk);
    chk("rst_wren", 32'(bus.rf_wren_o), 0);
    chk("rst_rden", 32'(bus.rf_rden_b_o), 0);
    chk("rst_busy", 32'(bus.rf_init_busy_o), 1);
    chk("rst_ack", 32'(bus.du_ack_o), 0);
    chk("rst_dat", bus.du_dat_o, 0);
    @(posedge clk); #1;
    prefill = 0;
    bus.fetch_rf_adr_valid_i = 0; bus.wb_rfd_adr_i = 7; bus.result_i = 32'h55;
    rst_n = 1;
    bad = 0; ea = 0; busy_n = 0;
    for (int c = 0; c < 100; c++) begin
      bus.wb_rf_wb_i = (c == collide);
      @(negedge clk);
      if (!bus.rf_init_busy_o) break;
      busy_n++;
      if (bus.du_ack_o) bad++;
      if (c == collide) begin
        if (!(bus.rf_wren_o && bus.rf_wrad_o == 7 && bus.rf_wrda_o == 32'h55)) bad++;
      end else begin
        if (!(bus.rf_wren_o && bus.rf_wrad_o == 5'(ea) && bus.rf_wrda_o == 0)) bad++;
        ea++;
      end
      @(posedge clk); #1;
    end
    bus.wb_rf_wb_i = 0;
    chk("clear_seq", 32'(bad), 0);
    @(posedge clk); #1;
  endtask
  task automatic du_op(input logic w, input logic [4:0] a, input logic [31:0] d,
                       output int lat, output logic [31:0] q);
    bus.du_req_i = 1; bus.du_we_i = w; bus.du_adr_i = a; bus.du_dat_i = d; bus.cpu_stall_i = 1;
    lat = -1; q = 0;
    for (int i = 0; i < 16; i++) begin
      bus.wb_rf_wb_i = (i < wb_hold);
      if (i == stall_drop) bus.cpu_stall_i = 0;
      @(negedge clk);
      tr_wren[i] = bus.rf_wren_o; tr_wrad[i] = bus.rf_wrad_o;
      tr_rden[i] = bus.rf_rden_b_o; tr_rdad[i] = bus.rf_rdad_b_o;
      if (bus.du_ack_o) begin
        lat = i;
        q = bus.du_dat_o;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    idle_inputs();
    wb_hold = 0; stall_drop = -1;
  endtask
  initial begin
    int n;
    int lat;
    int nz;
    int acks;
    int wrs;
    logic [31:0] q;
    tv[0] = '{0,0,0,0,0, 0,0,0, 0,0, 0,0,0, 0,0};
    tv[1] = '{0,0,0,0,0, 1,4,32'h44, 0,0, 1,4,32'h44, 0,0};
    tv[2] = '{0,0,0,0,0, 0,0,0, 1,10, 0,0,0, 1,10};
    tv[3] = '{0,0,0,0,0, 1,2,32'h22, 1,11, 1,2,32'h22, 1,11};
    tv[4] = '{0,1,1,6,32'h66, 0,0,0, 0,0, 0,0,0, 0,0};
    tv[5] = '{0,1,0,6,0, 0,0,0, 0,0, 0,0,0, 0,0};
    tv[6] = '{1,1,1,6,32'h66, 1,8,32'h88, 0,0, 1,8,32'h88, 0,0};
    tv[7] = '{1,1,0,6,0, 0,0,0, 1,12, 0,0,0, 1,12};
    idle_inputs();
    @(posedge clk); #1;
    do_clear(-1, n);
    chk("clear_busy_cycles", 32'(n), 32);
    nz = 0;
    for (int i = 0; i < 32; i++) if (mem[i] != 0) nz++;
    chk("clear_zero_words", 32'(nz), 0);
    do_clear(3, n);
    chk("clear_collide_busy_cycles", 32'(n), 33);
    for (int i = 0; i < 8; i++) begin
      bus.cpu_stall_i = tv[i].stall; bus.du_req_i = tv[i].req; bus.du_we_i = tv[i].we;
      bus.du_adr_i = tv[i].dadr; bus.du_dat_i = tv[i].ddat;
      bus.wb_rf_wb_i = tv[i].wb; bus.wb_rfd_adr_i = tv[i].wadr; bus.result_i = tv[i].res;
      bus.fetch_rf_adr_valid_i = tv[i].fv; bus.fetch_rfb_adr_i = tv[i].fadr;
      @(negedge clk);
      chk($sformatf("vec%0d_wren", i), 32'(bus.rf_wren_o), 32'(tv[i].e_wren));
      if (tv[i].e_wren) begin
        chk($sformatf("vec%0d_wrad", i), 32'(bus.rf_wrad_o), 32'(tv[i].e_wrad));
        chk($sformatf("vec%0d_wrda", i), bus.rf_wrda_o, tv[i].e_wrda);
      end
      chk($sformatf("vec%0d_rden", i), 32'(bus.rf_rden_b_o), 32'(tv[i].e_rden));
      if (tv[i].e_rden) chk($sformatf("vec%0d_rdad", i), 32'(bus.rf_rdad_b_o), 32'(tv[i].e_rdad));
      chk($sformatf("vec%0d_ack", i), 32'(bus.du_ack_o), 0);
      @(posedge clk); #1;
      idle_inputs();
    end
    du_op(1, 5, 32'hDEADBEEF, lat, q);
    chk("dwr_lat", 32'(lat), 1);
    chk("dwr_issue_adr", {26'd0, tr_wren[0], tr_wrad[0]}, {26'd0, 1'b1, 5'd5});
    chk("dwr_mem", mem[5], 32'hDEADBEEF);
    du_op(0, 5, 0, lat, q);
    chk("drd_lat", 32'(lat), 3);
    chk("drd_data", q, 32'hDEADBEEF);
    bus.wb_rfd_adr_i = 9; bus.result_i = 32'h1234; wb_hold = 1;
    du_op(0, 9, 0, lat, q);
    chk("byp_lat", 32'(lat), 3);
    chk("byp_data", q, 32'h1234);
    du_op(1, 12, 32'hC0C0C0C0, lat, q);
    du_op(1, 3, 32'h33333333, lat, q);
    bus.fetch_rf_adr_valid_i = 1; bus.fetch_rfb_adr_i = 12;
    @(posedge clk); #1;
    bus.fetch_rf_adr_valid_i = 0;
    du_op(0, 3, 0, lat, q);
    chk("rst_lat", 32'(lat), 3);
    chk("rst_data", q, 32'h33333333);
    chk("rst_rdad0", {26'd0, tr_rden[0], tr_rdad[0]}, {26'd0, 1'b1, 5'd3});
    chk("rst_rdad1", {26'd0, tr_rden[1], tr_rdad[1]}, {26'd0, 1'b1, 5'd12});
    chk("rst_portb_value", bus.rf_rdda_b_i, 32'hC0C0C0C0);
    bus.wb_rfd_adr_i = 1; bus.result_i = 32'h11; wb_hold = 4;
    du_op(1, 6, 32'h66, lat, q);
    chk("defer_lat", 32'(lat), 5);
    chk("defer_wb_slot", {26'd0, tr_wren[3], tr_wrad[3]}, {26'd0, 1'b1, 5'd1});
    chk("defer_issue_adr", {26'd0, tr_wren[4], tr_wrad[4]}, {26'd0, 1'b1, 5'd6});
    chk("defer_mem", mem[6], 32'h66);
    stall_drop = 1;
    du_op(0, 5, 0, lat, q);
    chk("stall_drop_lat", 32'(lat), 3);
    chk("stall_drop_data", q, 32'hDEADBEEF);
    bus.cpu_stall_i = 0; bus.du_req_i = 1; bus.du_we_i = 1; bus.du_adr_i = 7; bus.du_dat_i = 32'h77;
    acks = 0; wrs = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.du_ack_o) acks++;
      if (bus.rf_wren_o) wrs++;
      @(posedge clk); #1;
    end
    chk("gate_acks", 32'(acks), 0);
    chk("gate_writes", 32'(wrs), 0);
    idle_inputs();
    bus.du_req_i = 1; bus.du_adr_i = 5;
    @(posedge clk); #1;
    do_clear(-1, n);
    chk("midop_reset_busy_cycles", 32'(n), 32);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
